// File: rtl/mmio_port_responder.sv
// rtl/mmio_port_responder.sv - memory-mapped port responder with Req/Ack handshake and PortIn change tracking
module mmio_port_responder #(
    parameter logic [31:0] ADDR_BASE   = 32'h1001_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Req,
    input  logic        WriteEn,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ack,
    output logic        AddrError,
    input  logic [7:0]  PortIn,
    output logic [31:0] PortOut,
    output logic        InChanged
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    localparam logic [1:0] OFF_PORT_OUT = 2'd0;
    localparam logic [1:0] OFF_PORT_IN  = 2'd1;
    localparam logic [1:0] OFF_STATUS   = 2'd2;
    localparam logic [1:0] OFF_COUNT    = 2'd3;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        lat_we;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;
    logic        ack_q;
    logic        addr_error_q;

    logic [31:0] port_out;
    logic        status_flag;
    logic [15:0] change_count;
    logic [7:0]  sync_s1;
    logic [7:0]  sync_s2;
    logic [7:0]  port_prev;

    logic        lat_legal;
    logic        commit_wr;
    logic        change;

    // Word-aligned and inside the 16-byte window.
    function automatic logic is_legal(input logic [31:0] a);
        return (a[31:4] == ADDR_BASE[31:4]) && (a[1:0] == 2'b00);
    endfunction

    assign lat_legal = is_legal(lat_addr);
    assign commit_wr = (state == ST_RESP) && lat_we && lat_legal;
    assign change    = (sync_s2 != port_prev);

    assign Ack       = ack_q;
    assign AddrError = addr_error_q;
    assign PortOut   = port_out;
    assign InChanged = status_flag;

    // Two-flop synchronizer for PortIn plus the previous-value register used for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_s1   <= 8'd0;
            sync_s2   <= 8'd0;
            port_prev <= 8'd0;
        end else begin
            sync_s1   <= PortIn;
            sync_s2   <= sync_s1;
            port_prev <= sync_s2;
        end
    end

    // Sticky change flag (set beats W1C) and saturating change counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            status_flag  <= 1'b0;
            change_count <= 16'd0;
        end else begin
            if (change) begin
                status_flag <= 1'b1;
            end else if (commit_wr && (lat_addr[3:2] == OFF_STATUS) && lat_wdata[0]) begin
                status_flag <= 1'b0;
            end
            if (change && (change_count != 16'hFFFF)) begin
                change_count <= change_count + 16'd1;
            end
        end
    end

    // PORT_OUT register; a store takes effect at the edge that ends the response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            port_out <= 32'd0;
        end else if (commit_wr && (lat_addr[3:2] == OFF_PORT_OUT)) begin
            port_out <= lat_wdata;
        end
    end

    // Transaction FSM: latch the request, count wait states, then pulse Ack for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            wait_cnt     <= 4'd0;
            lat_we       <= 1'b0;
            lat_addr     <= 32'd0;
            lat_wdata    <= 32'd0;
            ack_q        <= 1'b0;
            addr_error_q <= 1'b0;
        end else begin
            ack_q        <= 1'b0;
            addr_error_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (Req) begin
                        lat_we    <= WriteEn;
                        lat_addr  <= Address;
                        lat_wdata <= WriteData;
                        if (WAIT_STATES == 0) begin
                            state        <= ST_RESP;
                            ack_q        <= 1'b1;
                            addr_error_q <= !is_legal(Address);
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state        <= ST_RESP;
                        ack_q        <= 1'b1;
                        addr_error_q <= !lat_legal;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Load data is taken from live register state during the Ack cycle; stores and errors return 0.
    always_comb begin
        ReadData = 32'd0;
        if (ack_q && !lat_we && lat_legal) begin
            case (lat_addr[3:2])
                OFF_PORT_OUT: ReadData = port_out;
                OFF_PORT_IN:  ReadData = {24'd0, port_prev};
                OFF_STATUS:   ReadData = {31'd0, status_flag};
                OFF_COUNT:    ReadData = {16'd0, change_count};
                default:      ReadData = 32'd0;
            endcase
        end
    end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor data bus: services load/store requests from the MIPS core with a Req/Ack handshake.
- Drives the processor's PortOut register and samples the 8-bit PortIn through a synchronizer.
- Tracks PortIn changes with a sticky flag and a saturating counter.
- Sits between the core's data-memory interface and the board pins, in the address window ADDR_BASE..ADDR_BASE+0xF.

Parameters:
- ADDR_BASE, 32'h1001_0000: base of the 16-byte register window; bits [3:0] ignored.
- WAIT_STATES, 1: extra cycles inserted before Ack (0..15).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- Req  in  1  requester asserts; held high until Ack is seen.
- WriteEn  in  1  1 = store, 0 = load; valid with Req.
- Address  in  32  byte address; valid with Req.
- WriteData  in  32  store data; valid with Req.
- ReadData  out  32  load data; valid only while Ack=1, else 0.
- Ack  out  1  one-cycle transaction-complete pulse.
- AddrError  out  1  high with Ack when the address is not a legal register.
- PortIn  in  8  asynchronous external input.
- PortOut  out  32  PORT_OUT register contents.
- InChanged  out  1  copy of STATUS[0].

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high.
- Reset clears all flops:
  - Ack=0, AddrError=0, ReadData=0, PortOut=0, InChanged=0.
  - CHANGE_COUNT=0, synchronizer stages=0, FSM=IDLE.
- Register map (offset = Address[3:0]):
  - 0x0 PORT_OUT: read/write.
  - 0x4 PORT_IN: read-only; {24'b0, synchronized PortIn}.
  - 0x8 STATUS: bit0 = change flag, write-1-to-clear; other bits read 0.
  - 0xC CHANGE_COUNT: read-only; {16'b0, count}.
- Writes to read-only offsets are ignored and raise no error.
- Address is legal iff Address[31:4]==ADDR_BASE[31:4] and Address[1:0]==2'b00. Otherwise:
  - AddrError=1 with Ack, ReadData=0, no register changes.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if Req=1 at an edge, latch Address, WriteEn and WriteData. Go to WAIT (load counter with WAIT_STATES-1), or straight to RESP if WAIT_STATES=0.
  - WAIT: decrement counter each cycle; go to RESP when it reaches 0.
  - RESP: Ack=1 for exactly one cycle; AddrError and ReadData are driven from the latched request.
    - A store commits at the edge ending RESP.
    - Load data reflects register state during the RESP cycle.
    - Next state is always IDLE.
- Latency: Ack is high in cycle WAIT_STATES+1 counting the cycle after the Req-sampling edge as cycle 1.
- Back-to-back: Req still high in the IDLE cycle after Ack starts a new transaction. The requester must drop Req in the cycle after Ack to avoid a repeat.
- Inputs other than Req are ignored outside IDLE; latched values are used.
- Synchronizer and change detection:
  - PortIn passes through two flops (s1, s2), then a third register (prev) captures s2.
  - change = (s2 != prev).
  - change sets STATUS[0] and increments CHANGE_COUNT, saturating at 16'hFFFF.
  - PORT_IN reads return prev.
- Same-cycle STATUS W1C and change: set wins, STATUS[0] stays 1.
- Writing 0 to STATUS[0] has no effect.
- After reset, nonzero PortIn is detected as a change: prev updates on the third edge after PortIn is stable.
- Reset mid-transaction: the request is abandoned, no Ack, no write; the requester must re-issue it.

Test Plan:
1. WAIT_STATES=1: store 32'hDEAD_BEEF to 0x1001_0000 with Req held -> Ack high exactly 2 cycles after the sampling edge; PortOut=32'hDEAD_BEEF the cycle after Ack; AddrError=0.
2. Load from 0x1001_0000 after test 1 -> ReadData=32'hDEAD_BEEF only during Ack; 0 in the cycles before and after.
3. PortIn 8'h00->8'h5A, wait 4 cycles; load 0x1001_0004 -> 32'h0000_005A. Load 0x1001_0008 -> 32'h1. Load 0x1001_000C -> 32'h1.
4. Store 32'h1 to 0x1001_0008 in the same cycle the synchronized PortIn changes -> STATUS[0] stays 1 and CHANGE_COUNT increments. Repeat the store with no change -> InChanged=0.
5. Load from 0x1001_0002 and from 0x2000_0000 -> Ack=1, AddrError=1, ReadData=0. Store to 0x1001_0004 -> Ack=1, AddrError=0, PORT_IN unchanged.
6. Assert reset during WAIT of a store 32'h1234 to PORT_OUT -> no Ack, PortOut=0, FSM IDLE. WAIT_STATES=0 build: Ack in the cycle right after Req is sampled. Hold Req for 2 Ack cycles -> two transactions, Ack pattern 1,0,1.
